// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - TLB constants, config-bus layout, entry types and translation helper
package tlb_pkg;
    localparam int TLB_Entry_num = 16;
    localparam int VPN2_W        = 19;
    localparam int ASID_W        = 8;
    localparam int PFN_W         = 20;

    localparam int CFG_IN_W    = 142;
    localparam int CFG_OUT_W   = 160;
    localparam int CFG_EHI_LSB = 0;
    localparam int CFG_LO0_LSB = 32;
    localparam int CFG_LO1_LSB = 64;
    localparam int CFG_IDX_LSB = 96;
    localparam int CFG_RND_LSB = 102;
    localparam int CFG_USED_W  = 108;

    localparam int OUT_EHI_LSB = 0;
    localparam int OUT_LO0_LSB = 32;
    localparam int OUT_LO1_LSB = 64;
    localparam int OUT_IDX_LSB = 96;
    localparam int OUT_PM_LSB  = 128;

    localparam int LO_PFN_LSB   = 6;
    localparam int LO_C_LSB     = 3;
    localparam int LO_D_BIT     = 2;
    localparam int LO_V_BIT     = 1;
    localparam int LO_G_BIT     = 0;
    localparam int EHI_VPN2_LSB = 13;
    localparam int EHI_ASID_LSB = 0;

    localparam logic [31:0] UNMAPPED_LO   = 32'h8000_0000;
    localparam logic [31:0] UNMAPPED_HI   = 32'hBFFF_FFFF;
    localparam logic [31:0] UNMAPPED_MASK = 32'h1FFF_FFFF;
    localparam logic [31:0] PROBE_MISS    = 32'h8000_0000;

    typedef struct packed {
        logic [PFN_W-1:0] pfn;
        logic [2:0]       c;
        logic             d;
        logic             v;
    } page_t;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        page_t             p1;
        page_t             p0;
    } entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        refill;
        logic        invalid;
        logic        modified;
    } lkp_t;

    // Faults are mutually exclusive: refill beats invalid beats modified.
    function automatic lkp_t translate(input logic [31:0] va, input logic wr, input logic hit,
                                       input logic [PFN_W-1:0] pfn, input logic d, input logic v);
        lkp_t r;
        r = '0;
        if (va >= UNMAPPED_LO && va <= UNMAPPED_HI) begin
            r.paddr = va & UNMAPPED_MASK;
        end else begin
            r.paddr = {pfn, va[11:0]};
            if (!hit)
                r.refill = 1'b1;
            else if (!v)
                r.invalid = 1'b1;
            else if (wr && !d)
                r.modified = 1'b1;
        end
        return r;
    endfunction
endpackage

// File: rtl/tlb_if.sv
// rtl/tlb_if.sv - CP0 config bus and instruction/data lookup ports of the TLB
interface tlb_if import tlb_pkg::*; #(
    parameter int IN_W  = CFG_IN_W,
    parameter int OUT_W = CFG_OUT_W
) ();
    logic             cp0_enable;
    logic             tlbwi;
    logic             tlbwr;
    logic             tlbp;
    logic             tlbr;
    logic [IN_W-1:0]  in_tlb_config;
    logic [OUT_W-1:0] out_tlb_config;
    logic             stall;
    logic             inst_req;
    logic [31:0]      inst_vaddr;
    logic             inst_resp;
    logic             inst_refill;
    logic             inst_invalid;
    logic [31:0]      inst_paddr;
    logic             data_req;
    logic             data_write;
    logic [31:0]      data_vaddr;
    logic             data_resp;
    logic             data_refill;
    logic             data_invalid;
    logic             data_modified;
    logic [31:0]      data_paddr;

    modport master (
        output cp0_enable, tlbwi, tlbwr, tlbp, tlbr, in_tlb_config, stall,
               inst_req, inst_vaddr, data_req, data_write, data_vaddr,
        input  out_tlb_config, inst_resp, inst_refill, inst_invalid, inst_paddr,
               data_resp, data_refill, data_invalid, data_modified, data_paddr
    );

    modport slave (
        input  cp0_enable, tlbwi, tlbwr, tlbp, tlbr, in_tlb_config, stall,
               inst_req, inst_vaddr, data_req, data_write, data_vaddr,
        output out_tlb_config, inst_resp, inst_refill, inst_invalid, inst_paddr,
               data_resp, data_refill, data_invalid, data_modified, data_paddr
    );
endinterface

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - VPN2/ASID comparator array with lowest-index priority encoder
module tlb_match import tlb_pkg::*; #(
    parameter  int N  = TLB_Entry_num,
    localparam int IW = $clog2(N)
) (
    input  logic [N*VPN2_W-1:0] i_vpn2_tab,
    input  logic [N*ASID_W-1:0] i_asid_tab,
    input  logic [N-1:0]        i_g_tab,
    input  logic [VPN2_W-1:0]   i_vpn2,
    input  logic [ASID_W-1:0]   i_asid,
    output logic                o_hit,
    output logic [IW-1:0]       o_idx
);
    logic [N-1:0] w_match;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < N; i++)
            w_match[i] = (i_vpn2_tab[i*VPN2_W +: VPN2_W] == i_vpn2) &&
                         (i_g_tab[i] || (i_asid_tab[i*ASID_W +: ASID_W] == i_asid));
    end

    always_comb begin
        o_hit = |w_match;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (w_match[i])
                o_idx = IW'(i);
    end
endmodule

// File: rtl/tlb.sv
// rtl/tlb.sv - 4 KB-page TLB: CP0 write/probe/read plus registered inst and data lookups
module tlb #(
    parameter int TLB_Entry_num        = tlb_pkg::TLB_Entry_num,
    parameter int in_tlb_config_width  = tlb_pkg::CFG_IN_W,
    parameter int out_tlb_config_width = tlb_pkg::CFG_OUT_W
) (
    input logic   clk,
    input logic   rst,
    tlb_if.slave  bus
);
    import tlb_pkg::*;
    localparam int IW = $clog2(TLB_Entry_num);

    logic [in_tlb_config_width-1:0]  w_cfg;
    logic [out_tlb_config_width-1:0] w_out;
    logic [31:0] w_ehi, w_lo0, w_lo1;
    logic [IW-1:0] w_idx, w_rnd, w_widx;
    logic w_we;
    entry_t w_new, w_rd;
    entry_t r_entry [TLB_Entry_num];

    assign w_cfg = bus.in_tlb_config;
    assign w_ehi = w_cfg[CFG_EHI_LSB +: 32];
    assign w_lo0 = w_cfg[CFG_LO0_LSB +: 32];
    assign w_lo1 = w_cfg[CFG_LO1_LSB +: 32];
    assign w_idx = w_cfg[CFG_IDX_LSB +: IW];
    assign w_rnd = w_cfg[CFG_RND_LSB +: IW];

    assign w_we   = bus.cp0_enable & (bus.tlbwi | bus.tlbwr);
    assign w_widx = bus.tlbwi ? w_idx : w_rnd;

    always_comb begin
        w_new       = '0;
        w_new.vpn2  = w_ehi[EHI_VPN2_LSB +: VPN2_W];
        w_new.asid  = w_ehi[EHI_ASID_LSB +: ASID_W];
        w_new.g     = w_lo0[LO_G_BIT] & w_lo1[LO_G_BIT];
        w_new.p0    = {w_lo0[LO_PFN_LSB +: PFN_W], w_lo0[LO_C_LSB +: 3], w_lo0[LO_D_BIT], w_lo0[LO_V_BIT]};
        w_new.p1    = {w_lo1[LO_PFN_LSB +: PFN_W], w_lo1[LO_C_LSB +: 3], w_lo1[LO_D_BIT], w_lo1[LO_V_BIT]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TLB_Entry_num; i++)
                r_entry[i] <= '0;
        end else if (w_we) begin
            r_entry[w_widx] <= w_new;
        end
    end

    logic [TLB_Entry_num*VPN2_W-1:0] w_vpn2_tab;
    logic [TLB_Entry_num*ASID_W-1:0] w_asid_tab;
    logic [TLB_Entry_num-1:0]        w_g_tab;

    always_comb begin
        w_vpn2_tab = '0;
        w_asid_tab = '0;
        w_g_tab    = '0;
        for (int i = 0; i < TLB_Entry_num; i++) begin
            w_vpn2_tab[i*VPN2_W +: VPN2_W] = r_entry[i].vpn2;
            w_asid_tab[i*ASID_W +: ASID_W] = r_entry[i].asid;
            w_g_tab[i]                     = r_entry[i].g;
        end
    end

    logic w_i_hit, w_d_hit, w_p_hit;
    logic [IW-1:0] w_i_idx, w_d_idx, w_p_idx;

    tlb_match #(.N(TLB_Entry_num)) u_match_inst (
        .i_vpn2_tab(w_vpn2_tab), .i_asid_tab(w_asid_tab), .i_g_tab(w_g_tab),
        .i_vpn2(bus.inst_vaddr[31:13]), .i_asid(w_ehi[7:0]), .o_hit(w_i_hit), .o_idx(w_i_idx));

    tlb_match #(.N(TLB_Entry_num)) u_match_data (
        .i_vpn2_tab(w_vpn2_tab), .i_asid_tab(w_asid_tab), .i_g_tab(w_g_tab),
        .i_vpn2(bus.data_vaddr[31:13]), .i_asid(w_ehi[7:0]), .o_hit(w_d_hit), .o_idx(w_d_idx));

    tlb_match #(.N(TLB_Entry_num)) u_match_probe (
        .i_vpn2_tab(w_vpn2_tab), .i_asid_tab(w_asid_tab), .i_g_tab(w_g_tab),
        .i_vpn2(w_ehi[31:13]), .i_asid(w_ehi[7:0]), .o_hit(w_p_hit), .o_idx(w_p_idx));

    // Probe and read see the array before any write landing on this edge.
    assign w_rd = r_entry[w_idx];

    always_comb begin
        w_out = '0;
        w_out[OUT_EHI_LSB +: 32] = {w_rd.vpn2, 5'b0, w_rd.asid};
        w_out[OUT_LO0_LSB +: 32] = {6'b0, w_rd.p0.pfn, w_rd.p0.c, w_rd.p0.d, w_rd.p0.v, w_rd.g};
        w_out[OUT_LO1_LSB +: 32] = {6'b0, w_rd.p1.pfn, w_rd.p1.c, w_rd.p1.d, w_rd.p1.v, w_rd.g};
        w_out[OUT_IDX_LSB +: 32] = w_p_hit ? 32'(w_p_idx) : PROBE_MISS;
    end
    assign bus.out_tlb_config = w_out;

    page_t w_i_pg, w_d_pg;
    lkp_t  w_inst, w_data, r_inst, r_data;
    logic  r_inst_resp, r_data_resp;

    assign w_i_pg = bus.inst_vaddr[12] ? r_entry[w_i_idx].p1 : r_entry[w_i_idx].p0;
    assign w_d_pg = bus.data_vaddr[12] ? r_entry[w_d_idx].p1 : r_entry[w_d_idx].p0;
    assign w_inst = translate(bus.inst_vaddr, 1'b0, w_i_hit, w_i_pg.pfn, w_i_pg.d, w_i_pg.v);
    assign w_data = translate(bus.data_vaddr, bus.data_write, w_d_hit, w_d_pg.pfn, w_d_pg.d, w_d_pg.v);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inst      <= '0;
            r_data      <= '0;
            r_inst_resp <= 1'b0;
            r_data_resp <= 1'b0;
        end else if (!bus.stall) begin
            r_inst_resp <= bus.inst_req;
            r_data_resp <= bus.data_req;
            if (bus.inst_req)
                r_inst <= w_inst;
            if (bus.data_req)
                r_data <= w_data;
        end
    end

    assign bus.inst_resp     = r_inst_resp;
    assign bus.inst_refill   = r_inst.refill;
    assign bus.inst_invalid  = r_inst.invalid;
    assign bus.inst_paddr    = r_inst.paddr;
    assign bus.data_resp     = r_data_resp;
    assign bus.data_refill   = r_data.refill;
    assign bus.data_invalid  = r_data.invalid;
    assign bus.data_modified = r_data.modified;
    assign bus.data_paddr    = r_data.paddr;

    logic w_unused;
    assign w_unused = ^{w_cfg[in_tlb_config_width-1:CFG_USED_W], w_cfg[CFG_IDX_LSB+IW +: 6-IW],
                        w_cfg[CFG_RND_LSB+IW +: 6-IW], w_ehi[12:8], w_lo0[31:26], w_lo1[31:26],
                        w_i_pg.c, w_d_pg.c, r_inst.modified, bus.tlbp, bus.tlbr};
endmodule

// File: tb/tb_tlb.sv
// tb/tb_tlb.sv - scoreboard bench for the TLB: directed writes, probes, reads and lookups
module tb_tlb;
    import tlb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tlb_if bus ();
    tlb dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] paddr;
        bit          chk_pa;
        logic        refill;
        logic        invalid;
        logic        modified;
    } exp_t;

    exp_t q_inst[$];
    exp_t q_data[$];
    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic cmp_resp(input string name, input logic [31:0] pa, input logic rf,
                            input logic iv, input logic md, input exp_t e);
        checks++;
        if ((e.chk_pa && pa !== e.paddr) || rf !== e.refill || iv !== e.invalid || md !== e.modified) begin
            errors++;
            $display("FAIL %s actual pa=%08h rf=%b iv=%b md=%b expected pa=%08h(chk=%0d) rf=%b iv=%b md=%b",
                     name, pa, rf, iv, md, e.paddr, e.chk_pa, e.refill, e.invalid, e.modified);
        end
    endtask

    // Monitor: a response seen after an unstalled edge is new and pops the queue;
    // one seen after a stalled edge must repeat the last popped value.
    initial begin
        exp_t last_i, last_d;
        logic st, rs;
        last_i = '{default: '0};
        last_d = '{default: '0};
        forever begin
            @(posedge clk);
            st = bus.stall;
            rs = rst;
            @(negedge clk);
            if (rs) begin
                if (bus.inst_resp) begin
                    if (st) begin
                        cmp_resp("inst_held", bus.inst_paddr, bus.inst_refill, bus.inst_invalid, 1'b0, last_i);
                    end else if (q_inst.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL inst_unexpected_resp actual=1 expected=0");
                    end else begin
                        last_i = q_inst.pop_front();
                        cmp_resp("inst_resp", bus.inst_paddr, bus.inst_refill, bus.inst_invalid, 1'b0, last_i);
                    end
                end
                if (bus.data_resp) begin
                    if (st) begin
                        cmp_resp("data_held", bus.data_paddr, bus.data_refill, bus.data_invalid, bus.data_modified, last_d);
                    end else if (q_data.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL data_unexpected_resp actual=1 expected=0");
                    end else begin
                        last_d = q_data.pop_front();
                        cmp_resp("data_resp", bus.data_paddr, bus.data_refill, bus.data_invalid, bus.data_modified, last_d);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input logic [5:0] rnd, input logic [5:0] idx, input logic [31:0] lo1,
                           input logic [31:0] lo0, input logic [31:0] ehi);
        bus.in_tlb_config = {34'b0, rnd, idx, lo1, lo0, ehi};
    endtask

    task automatic arm_inst(input logic [31:0] va, input logic [31:0] pa, input bit chk,
                            input logic rf, input logic iv);
        exp_t e;
        e = '{paddr: pa, chk_pa: chk, refill: rf, invalid: iv, modified: 1'b0};
        bus.inst_req = 1'b1;
        bus.inst_vaddr = va;
        q_inst.push_back(e);
    endtask

    task automatic arm_data(input logic [31:0] va, input logic wr, input logic [31:0] pa, input bit chk,
                            input logic rf, input logic iv, input logic md);
        exp_t e;
        e = '{paddr: pa, chk_pa: chk, refill: rf, invalid: iv, modified: md};
        bus.data_req = 1'b1;
        bus.data_write = wr;
        bus.data_vaddr = va;
        q_data.push_back(e);
    endtask

    task automatic strobe(input logic wi, input logic wr, input logic en);
        bus.tlbwi = wi;
        bus.tlbwr = wr;
        bus.cp0_enable = en;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        bus.data_write = 1'b0;
        bus.tlbwi = 1'b0;
        bus.tlbwr = 1'b0;
        bus.tlbp = 1'b0;
        bus.tlbr = 1'b0;
        bus.cp0_enable = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [31:0] ehi, input logic [31:0] lo0,
                              input logic [31:0] lo1);
        #1;
        check32({name, "_ehi"}, bus.out_tlb_config[OUT_EHI_LSB +: 32], ehi);
        check32({name, "_lo0"}, bus.out_tlb_config[OUT_LO0_LSB +: 32], lo0);
        check32({name, "_lo1"}, bus.out_tlb_config[OUT_LO1_LSB +: 32], lo1);
        check32({name, "_pagemask"}, bus.out_tlb_config[OUT_PM_LSB +: 32], 32'h0);
    endtask

    initial begin
        bus.cp0_enable = 0; bus.tlbwi = 0; bus.tlbwr = 0; bus.tlbp = 0; bus.tlbr = 0;
        bus.stall = 0; bus.inst_req = 0; bus.inst_vaddr = 0;
        bus.data_req = 0; bus.data_write = 0; bus.data_vaddr = 0;
        set_cfg(0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        step();
        check32("reset_inst_resp", {31'b0, bus.inst_resp}, 32'h0);
        check32("reset_data_resp", {31'b0, bus.data_resp}, 32'h0);
        check32("reset_inst_paddr", bus.inst_paddr, 32'h0);
        check32("reset_data_paddr", bus.data_paddr, 32'h0);
        check_read("reset_tlbr0", 32'h0, 32'h0, 32'h0);
        rst = 1'b1;

        arm_inst(32'h0000_0000, 32'h0000_0000, 1, 0, 1);
        step();

        // Write entry 3 while a lookup of the same page is in flight: old contents miss.
        set_cfg(0, 3, 32'h0000_2047, 32'h0000_1047, 32'h0040_2005);
        strobe(1, 0, 1);
        arm_inst(32'h0040_2ABC, 32'h0, 0, 1, 0);
        step();
        arm_inst(32'h0040_2ABC, 32'h0004_1ABC, 1, 0, 0);
        step();
        step();

        check_read("tlbr3", 32'h0040_2005, 32'h0000_1047, 32'h0000_2047);
        check32("tlbp_hit", bus.out_tlb_config[OUT_IDX_LSB +: 32], 32'h0000_0003);
        set_cfg(0, 3, 0, 0, 32'h0040_4005);
        #1;
        check32("tlbp_miss", bus.out_tlb_config[OUT_IDX_LSB +: 32], 32'h8000_0000);

        // Rewrite entry 3 with Lo1 D=0; probe/read in the same cycle see the old Lo1.
        set_cfg(0, 3, 32'h0000_2043, 32'h0000_1047, 32'h0040_2005);
        strobe(1, 0, 1);
        bus.tlbp = 1'b1;
        bus.tlbr = 1'b1;
        #1;
        check32("tlbr_prewrite_lo1", bus.out_tlb_config[OUT_LO1_LSB +: 32], 32'h0000_2047);
        check32("tlbp_prewrite", bus.out_tlb_config[OUT_IDX_LSB +: 32], 32'h0000_0003);
        step();
        #1;
        check32("tlbr_postwrite_lo1", bus.out_tlb_config[OUT_LO1_LSB +: 32], 32'h0000_2043);

        arm_data(32'h0040_3000, 1, 32'h0008_1000, 1, 0, 0, 1);
        step();
        arm_data(32'h0040_3000, 0, 32'h0008_1000, 1, 0, 0, 0);
        arm_inst(32'h0040_2004, 32'h0004_1004, 1, 0, 0);
        step();
        arm_data(32'h0080_0000, 1, 32'h0, 0, 1, 0, 0);
        step();

        set_cfg(6'd5, 0, 32'h0000_3045, 32'h0000_3045, 32'h0060_0005);
        strobe(0, 1, 1);
        step();
        arm_inst(32'h0060_0010, 32'h000C_1010, 1, 0, 1);
        step();

        set_cfg(6'd8, 6'd7, 32'h0000_1047, 32'h0000_1047, 32'h0080_0005);
        strobe(1, 1, 1);
        step();
        check_read("tlbr7_wi_wins", 32'h0080_0005, 32'h0000_1047, 32'h0000_1047);
        set_cfg(0, 6'd8, 0, 0, 32'h0);
        check_read("tlbr8_not_written", 32'h0, 32'h0, 32'h0);

        set_cfg(0, 6'd9, 32'h0000_1047, 32'h0000_1047, 32'h0090_0005);
        strobe(1, 0, 0);
        step();
        check_read("tlbr9_no_enable", 32'h0, 32'h0, 32'h0);

        set_cfg(0, 6'd10, 32'h0000_1006, 32'h0000_1006, 32'h00A0_0007);
        strobe(1, 0, 1);
        step();
        arm_data(32'h00A0_0123, 1, 32'h0004_0123, 1, 0, 0, 0);
        step();
        set_cfg(0, 0, 0, 0, 32'h00A0_0005);
        arm_data(32'h00A0_0123, 0, 32'h0, 0, 1, 0, 0);
        step();

        // Entry 2 duplicates entry 3's page: the lower index must win.
        set_cfg(0, 6'd2, 32'h0000_2047, 32'h0000_5047, 32'h0040_2005);
        strobe(1, 0, 1);
        step();
        arm_inst(32'h0040_2ABC, 32'h0014_1ABC, 1, 0, 0);
        step();
        bus.stall = 1'b1;
        bus.inst_req = 1'b1;
        bus.inst_vaddr = 32'h0080_0000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check32("stall_inst_resp", {31'b0, bus.inst_resp}, 32'h1);
            check32("stall_inst_paddr", bus.inst_paddr, 32'h0014_1ABC);
        end
        bus.stall = 1'b0;
        arm_inst(32'hA000_1234, 32'h0000_1234, 1, 0, 0);
        step();
        step();

        // Reset mid-stream discards the pending requests.
        bus.inst_req = 1'b1;
        bus.inst_vaddr = 32'h0040_2ABC;
        bus.data_req = 1'b1;
        bus.data_vaddr = 32'h0040_3000;
        rst = 1'b0;
        step();
        rst = 1'b1;
        check32("midrst_inst_resp", {31'b0, bus.inst_resp}, 32'h0);
        check32("midrst_data_resp", {31'b0, bus.data_resp}, 32'h0);
        check32("midrst_inst_paddr", bus.inst_paddr, 32'h0);
        set_cfg(0, 6'd3, 0, 0, 32'h0);
        check_read("midrst_tlbr3", 32'h0, 32'h0, 32'h0);
        set_cfg(0, 6'd7, 0, 0, 32'h0);
        check_read("midrst_tlbr7", 32'h0, 32'h0, 32'h0);
        arm_data(32'h0000_0000, 0, 32'h0, 1, 0, 1, 0);
        step();
        step();
        step();

        check32("inst_queue_empty", q_inst.size(), 32'h0);
        check32("data_queue_empty", q_data.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
